// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop input synchroniser, mid-bit sampling, optional parity,
// 1/2 stop bits, false-start rejection and a valid/ready holding register with error flags.
module uart_rx_os #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = 4;
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic             PAR_ODD = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_e;

  logic [1:0]           sync_q;
  logic                 rx_s;
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 fe_q, fe_d;
  logic                 pe_q, pe_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;
  logic                 sample_c;
  logic                 complete_c;

  assign rx_s = sync_q[1];

  // Two-flop synchroniser; resets to idle-high so reset never looks like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx};
  end

  // Frame sequencing and holding-register update
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shreg_d      = shreg_q;
    fe_d         = fe_q;
    pe_d         = pe_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = 1'b0;
    complete_c   = 1'b0;
    sample_c     = (cnt_q == CNT_LAST);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = '0;
            fe_d    = 1'b0;
            pe_d    = 1'b0;
          end
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (sample_c) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (sample_c) begin
          cnt_d   = '0;
          pe_d    = (^shreg_q) ^ rx_s ^ PAR_ODD;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (sample_c) begin
          cnt_d = '0;
          idx_d = idx_q + IDX_W'(1);
          if (!rx_s) fe_d = 1'b1;
          if (idx_q == IDX_STOP_LAST) begin
            idx_d      = '0;
            complete_c = 1'b1;
            state_d    = rx_s ? S_IDLE : S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    // A word completing while the consumer drains the old one still loads
    if (complete_c) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shreg_q;
        frame_err_d  = fe_q | ~rx_s;
        parity_err_d = pe_q;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shreg_q      <= '0;
      fe_q         <= 1'b0;
      pe_q         <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shreg_q      <= shreg_d;
      fe_q         <= fe_d;
      pe_q         <= pe_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: an 8N1 receiver and an 8E1 receiver share clock, reset and rx_ready.
module tb_uart_rx_os;

  localparam int CPB = 16;
  // Edges from the start-bit launch edge to the edge that loads the word
  localparam int LAT_8N1 = 155;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_p = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data, rx_data_p;
  logic       rx_valid, frame_err, parity_err, overrun, busy;
  logic       rx_valid_p, frame_err_p, parity_err_p, overrun_p, busy_p;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_os u_dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .parity_err(parity_err),
    .overrun(overrun), .busy(busy)
  );

  uart_rx_os #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut_p (
    .clk(clk), .rst(rst), .rx(rx_p), .rx_data(rx_data_p), .rx_valid(rx_valid_p),
    .rx_ready(rx_ready), .frame_err(frame_err_p), .parity_err(parity_err_p),
    .overrun(overrun_p), .busy(busy_p)
  );

  // Observers: valid rises, overrun cycles, accepted words, hold violations
  int rise0 = 0, ovr0 = 0, hold_viol = 0, rise_cyc0 = 0, ovr_cyc0 = 0;
  logic [7:0] acc_data0 = '0, pd0 = '0;
  logic acc_fe0 = 0, acc_pe0 = 0, pv0 = 0, pr0 = 0, pfe0 = 0, ppe0 = 0;
  int rise1 = 0;
  logic [7:0] acc_data1 = '0;
  logic acc_fe1 = 0, acc_pe1 = 0, pv1 = 0;

  always @(negedge clk) begin
    if (rx_valid && !pv0) begin rise0++; rise_cyc0 = cyc; end
    if (overrun) begin ovr0++; ovr_cyc0 = cyc; end
    if (rx_valid && rx_ready) begin acc_data0 = rx_data; acc_fe0 = frame_err; acc_pe0 = parity_err; end
    if (!rst && pv0 && !pr0 && (rx_data !== pd0 || frame_err !== pfe0 || parity_err !== ppe0))
      hold_viol++;
    pv0 = rx_valid; pr0 = rx_ready; pd0 = rx_data; pfe0 = frame_err; ppe0 = parity_err;
  end

  always @(negedge clk) begin
    if (rx_valid_p && !pv1) rise1++;
    if (rx_valid_p && rx_ready) begin acc_data1 = rx_data_p; acc_fe1 = frame_err_p; acc_pe1 = parity_err_p; end
    pv1 = rx_valid_p;
  end

  task automatic set_line(input int line, input logic v);
    if (line == 0) rx = v;
    else           rx_p = v;
  endtask

  // Start bit, 8 data bits LSB first, optional parity, stop level held stop_len bit times, then 2 idle bits
  task automatic send_frame(input int line, input logic [7:0] d, input bit use_par,
                            input logic pbit, input logic stop, input int stop_len);
    @(posedge clk); #1;
    start_cyc = cyc;
    set_line(line, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk); #1;
      set_line(line, d[i]);
    end
    if (use_par) begin
      repeat (CPB) @(posedge clk); #1;
      set_line(line, pbit);
    end
    repeat (CPB) @(posedge clk); #1;
    set_line(line, stop);
    repeat (CPB * stop_len) @(posedge clk); #1;
    set_line(line, 1'b1);
    repeat (CPB * 2) @(posedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk); #1;
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    n_vec++; if ({frame_err, parity_err, overrun} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {frame_err, parity_err, overrun}); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if ({rx_valid_p, overrun_p, busy_p} !== 3'b000) begin n_err++; $display("FAIL reset_par_dut: got %b expected 000", {rx_valid_p, overrun_p, busy_p}); end
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int r0, o0;
    r0 = rise0; o0 = ovr0;
    rx_ready = 1'b1;
    send_frame(0, 8'hA5, 0, 1'b0, 1'b1, 1);
    n_vec++; if (rise0 - r0 != 1) begin n_err++; $display("FAIL basic_pulses: got %0d expected 1", rise0 - r0); end
    n_vec++; if (acc_data0 !== 8'hA5) begin n_err++; $display("FAIL basic_data: got %h expected a5", acc_data0); end
    n_vec++; if ({acc_fe0, acc_pe0} !== 2'b00) begin n_err++; $display("FAIL basic_flags: got %b expected 00", {acc_fe0, acc_pe0}); end
    n_vec++; if (ovr0 != o0) begin n_err++; $display("FAIL basic_overrun: got %0d expected 0", ovr0 - o0); end
    n_vec++; if (rise_cyc0 - start_cyc != LAT_8N1) begin n_err++; $display("FAIL basic_latency: got %0d expected %0d", rise_cyc0 - start_cyc, LAT_8N1); end
    n_vec++; if ({rx_valid, busy} !== 2'b00) begin n_err++; $display("FAIL basic_idle: got %b expected 00", {rx_valid, busy}); end
  endtask

  task automatic test_parity;
    int r1;
    rx_ready = 1'b1;
    r1 = rise1;
    send_frame(1, 8'h03, 1, 1'b1, 1'b1, 1);
    n_vec++; if (rise1 - r1 != 1) begin n_err++; $display("FAIL par_bad_pulses: got %0d expected 1", rise1 - r1); end
    n_vec++; if (acc_data1 !== 8'h03) begin n_err++; $display("FAIL par_bad_data: got %h expected 03", acc_data1); end
    n_vec++; if ({acc_pe1, acc_fe1} !== 2'b10) begin n_err++; $display("FAIL par_bad_flags: got pe,fe=%b expected 10", {acc_pe1, acc_fe1}); end
    r1 = rise1;
    send_frame(1, 8'h03, 1, 1'b0, 1'b1, 1);
    n_vec++; if (rise1 - r1 != 1) begin n_err++; $display("FAIL par_good_pulses: got %0d expected 1", rise1 - r1); end
    n_vec++; if (acc_data1 !== 8'h03) begin n_err++; $display("FAIL par_good_data: got %h expected 03", acc_data1); end
    n_vec++; if ({acc_pe1, acc_fe1} !== 2'b00) begin n_err++; $display("FAIL par_good_flags: got pe,fe=%b expected 00", {acc_pe1, acc_fe1}); end
  endtask

  task automatic test_break;
    int r0;
    r0 = rise0;
    rx_ready = 1'b1;
    fork
      send_frame(0, 8'h5A, 0, 1'b0, 1'b0, 20);
      begin
        repeat (250) @(posedge clk); #1;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL break_busy: got %b expected 1", busy); end
        n_vec++; if (rise0 - r0 != 1) begin n_err++; $display("FAIL break_delivered: got %0d expected 1", rise0 - r0); end
      end
    join
    n_vec++; if (acc_data0 !== 8'h5A) begin n_err++; $display("FAIL break_data: got %h expected 5a", acc_data0); end
    n_vec++; if ({acc_fe0, acc_pe0} !== 2'b10) begin n_err++; $display("FAIL break_flags: got fe,pe=%b expected 10", {acc_fe0, acc_pe0}); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL break_release: got busy %b expected 0", busy); end
    n_vec++; if (rise0 - r0 != 1) begin n_err++; $display("FAIL break_no_retrigger: got %0d words expected 1", rise0 - r0); end
  endtask

  task automatic test_glitch;
    int r0;
    r0 = rise0;
    @(posedge clk); #1 rx = 1'b0;
    repeat (3) @(posedge clk); #1 rx = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL glitch_start: got busy %b expected 1", busy); end
    repeat (30) @(posedge clk); #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_reject: got busy %b expected 0", busy); end
    n_vec++; if (rise0 != r0) begin n_err++; $display("FAIL glitch_no_word: got %0d words expected 0", rise0 - r0); end
  endtask

  task automatic test_overrun;
    int o0, s22;
    rx_ready = 1'b0;
    o0 = ovr0;
    send_frame(0, 8'h11, 0, 1'b0, 1'b1, 1);
    send_frame(0, 8'h22, 0, 1'b0, 1'b1, 1);
    s22 = start_cyc;
    n_vec++; if (rx_data !== 8'h11) begin n_err++; $display("FAIL ovr_held_data: got %h expected 11", rx_data); end
    n_vec++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL ovr_held_valid: got %b expected 1", rx_valid); end
    n_vec++; if (ovr0 - o0 != 1) begin n_err++; $display("FAIL ovr_pulse_cycles: got %0d expected 1", ovr0 - o0); end
    n_vec++; if (ovr_cyc0 - s22 != LAT_8N1) begin n_err++; $display("FAIL ovr_pulse_time: got %0d expected %0d", ovr_cyc0 - s22, LAT_8N1); end
    o0 = ovr0;
    fork
      send_frame(0, 8'h22, 0, 1'b0, 1'b1, 1);
      begin
        repeat (LAT_8N1) @(posedge clk); #1 rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;
      end
    join
    n_vec++; if (rx_data !== 8'h22) begin n_err++; $display("FAIL ovr_same_cycle_data: got %h expected 22", rx_data); end
    n_vec++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL ovr_same_cycle_valid: got %b expected 1", rx_valid); end
    n_vec++; if (ovr0 != o0) begin n_err++; $display("FAIL ovr_same_cycle_pulse: got %0d expected 0", ovr0 - o0); end
    n_vec++; if (hold_viol != 0) begin n_err++; $display("FAIL ovr_hold_stable: got %0d changes expected 0", hold_viol); end
    rx_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL ovr_drain: got %b expected 0", rx_valid); end
  endtask

  task automatic test_reset_mid;
    int r0;
    r0 = rise0;
    rx_ready = 1'b1;
    @(posedge clk); #1 rx = 1'b0;
    repeat (5 * CPB) @(posedge clk); #1 rx = 1'b1;
    repeat (8) @(posedge clk); #1;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    #1;
    n_vec++; if ({busy, rx_valid} !== 2'b00) begin n_err++; $display("FAIL rstmid_async: got %b expected 00", {busy, rx_valid}); end
    repeat (3) @(posedge clk); #1 rst = 1'b0;
    repeat (40) @(posedge clk); #1;
    n_vec++; if (rise0 != r0) begin n_err++; $display("FAIL rstmid_no_partial: got %0d words expected 0", rise0 - r0); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_idle: got %b expected 0", busy); end
    send_frame(0, 8'hC3, 0, 1'b0, 1'b1, 1);
    n_vec++; if (rise0 - r0 != 1) begin n_err++; $display("FAIL rstmid_next_pulses: got %0d expected 1", rise0 - r0); end
    n_vec++; if (acc_data0 !== 8'hC3) begin n_err++; $display("FAIL rstmid_next_data: got %h expected c3", acc_data0); end
    n_vec++; if ({acc_fe0, acc_pe0} !== 2'b00) begin n_err++; $display("FAIL rstmid_next_flags: got %b expected 00", {acc_fe0, acc_pe0}); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_break;
    test_glitch;
    test_overrun;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised, oversampling UART receiver; next generation of the team's 8-bit receiver.
- Adds: input synchroniser, mid-bit sampling from a baud counter, configurable data width, optional parity, 1 or 2 stop bits, false-start rejection, framing/parity/overrun reporting.
- Adds a valid/ready output holding register.
- Sits between the board RX pin and the uTPU command/byte FIFO.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per UART bit; must be >= 4; even values only.
- DATA_BITS, 8: data bits per frame, 5..9, LSB first.
- PARITY_EN, 0: 1 = a parity bit follows the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- rx  input  1  serial line, asynchronous to clk, idle high
- rx_data  output  DATA_BITS  received word, held while rx_valid
- rx_valid  output  1  word available
- rx_ready  input  1  consumer accepts word when rx_valid & rx_ready
- frame_err  output  1  attribute of held word: a stop bit was sampled low
- parity_err  output  1  attribute of held word: parity mismatch
- overrun  output  1  one-cycle pulse: a completed frame was dropped
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset values: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0, FSM=IDLE, both synchroniser flops=1.
- Reset mid-frame aborts the frame immediately; no partial word is delivered.
- Synchroniser: rx passes through 2 flops; all logic uses the synchronised value rx_s.
- Baud counter: cnt, width clog2(CLKS_PER_BIT).
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE:
  - rx_s==0 -> START, cnt=0.
- START:
  - At cnt==CLKS_PER_BIT/2-1 (mid start bit), sample rx_s.
  - rx_s==1 -> false start, back to IDLE, nothing reported.
  - rx_s==0 -> DATA, cnt=0, bit index=0.
- DATA:
  - Sample every CLKS_PER_BIT cycles (cnt==CLKS_PER_BIT-1, then cnt=0).
  - Shift bits into a shift register, LSB first.
  - After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
- PARITY:
  - One sample.
  - parity error when (XOR of data bits ^ sampled bit ^ PARITY_ODD) != 0.
- STOP:
  - STOP_BITS samples at the same spacing.
  - Any low stop sample sets the frame error.
  - After the last stop sample, complete the frame (see below).
  - Go to IDLE if the last sample was 1, else BREAK.
- BREAK:
  - Wait for rx_s==1, then IDLE.
  - Prevents a held-low line from retriggering a start.
- Frame completion, registered on the cycle after the last stop sample:
  - If holding register is free, or rx_valid & rx_ready in that same cycle: load rx_data, frame_err, parity_err; rx_valid=1; no overrun.
  - Otherwise: new word discarded, held word unchanged, overrun=1 for exactly one cycle.
- Frames with errors are still delivered, flagged by frame_err/parity_err.
- Handshake:
  - rx_valid stays high until a cycle with rx_ready=1, then clears on the next edge unless a new word loads in that same cycle.
  - rx_data and the flags must not change while rx_valid=1 and rx_ready=0.
- Latency: rx_valid rises 2 (synchroniser) + 1 cycles after rx physically reaches mid last-stop-bit.
- busy=1 in every state except IDLE.

Test Plan:
- Defaults (CLKS_PER_BIT=16, 8N1), send 0xA5, rx_ready=1 -> single rx_valid pulse, rx_data=0xA5, frame_err=0, parity_err=0, overrun=0.
- PARITY_EN=1, PARITY_ODD=0, send 0x03 with parity bit 1 -> rx_data=0x03, parity_err=1; repeat with parity bit 0 -> parity_err=0.
- Send 0x5A with stop bit driven 0 for 20 bit times -> rx_valid with frame_err=1, rx_data=0x5A; busy stays 1 until rx returns high; no second frame detected.
- 3-cycle low glitch on idle rx -> START entered, rejected at mid-bit; rx_valid never asserts, busy returns to 0.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses 1 cycle at end of 0x22; with rx_ready=1 exactly on 0x22's completion cycle -> 0x22 loaded, overrun=0.
- Assert rst during data bit 4 of a frame, release, then send 0xC3 -> no word from the aborted frame; 0xC3 received correctly.
